// File: rtl/result_bcd_converter.sv
// Sequential two's-complement to sign/BCD converter (double dabble, one bit per clock)
// with start/busy/valid handshake and leading-zero blank mask for the display mux.
module result_bcd_converter #(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      din,
   output logic                  busy,
   output logic                  valid,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned SW = 4 * DIGITS;
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    mag_q, mag_d;
   logic [SW-1:0]       scr_q, scr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                negint_q, negint_d;
   logic                valid_q, valid_d;
   logic                neg_q, neg_d;
   logic [SW-1:0]       bcd_q, bcd_d;
   logic [DIGITS-1:0]   blank_q, blank_d;

   logic [WIDTH-1:0]    din_mag;
   logic [SW-1:0]       scr_adj;
   logic [3:0]          dig;
   logic [SW+WIDTH-1:0] shifted;
   logic [DIGITS-1:0]   blank_calc;
   logic                zero_run;

   // Unsigned WIDTH-bit negate so the most negative input maps to 2^(WIDTH-1).
   assign din_mag = din[WIDTH-1] ? (~din + WIDTH'(1)) : din;

   always_comb begin
      dig     = '0;
      scr_adj = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         dig = scr_q[4*i +: 4];
         scr_adj[4*i +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
      end
   end

   assign shifted = {scr_adj, mag_q} << 1;

   // Walk from the most significant digit down; the ones digit is never blanked.
   always_comb begin
      zero_run   = 1'b1;
      blank_calc = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         zero_run = zero_run & (scr_q[4*(DIGITS-1-k) +: 4] == 4'd0);
         if (k != DIGITS - 1) begin
            blank_calc[DIGITS-1-k] = zero_run;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      scr_d    = scr_q;
      cnt_d    = cnt_q;
      negint_d = negint_q;
      valid_d  = 1'b0;
      neg_d    = neg_q;
      bcd_d    = bcd_q;
      blank_d  = blank_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               negint_d = din[WIDTH-1];
               mag_d    = din_mag;
               scr_d    = '0;
               cnt_d    = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scr_d = shifted[SW+WIDTH-1:WIDTH];
            mag_d = shifted[WIDTH-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            bcd_d   = scr_q;
            neg_d   = negint_q;
            blank_d = blank_calc;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mag_q    <= '0;
         scr_q    <= '0;
         cnt_q    <= '0;
         negint_q <= 1'b0;
         valid_q  <= 1'b0;
         neg_q    <= 1'b0;
         bcd_q    <= '0;
         blank_q  <= BLANK_RST;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         scr_q    <= scr_d;
         cnt_q    <= cnt_d;
         negint_q <= negint_d;
         valid_q  <= valid_d;
         neg_q    <= neg_d;
         bcd_q    <= bcd_d;
         blank_q  <= blank_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign valid = valid_q;
   assign neg   = neg_q;
   assign bcd   = bcd_q;
   assign blank = blank_q;

endmodule
